// File: rtl/buffer_bank_manager_if.sv
// Write-side bus of buffer_bank_manager: the ADC sample stream, the RAM write port
// and the bank ready/release toggle handshake with the read domain.
interface buffer_bank_manager_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned BANK_DEPTH = 8192,
    parameter int unsigned NUM_BANKS  = 4
);
    localparam int unsigned AW = $clog2(BANK_DEPTH);
    localparam int unsigned IW = $clog2(NUM_BANKS);

    logic                  isWriting;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  bankReleaseToggle;
    logic                  wrEnable;
    logic [IW+AW-1:0]      wrAddr;
    logic [DATA_WIDTH-1:0] wrData;
    logic                  bankReadyToggle;
    logic [IW-1:0]         readBank;
    logic [IW:0]           occupiedBanks;
    logic                  bufferOverflow;
    logic [15:0]           droppedCount;

    // Sample source / read side
    modport master (
        output isWriting, dataIn, bankReleaseToggle,
        input  wrEnable, wrAddr, wrData, bankReadyToggle, readBank,
               occupiedBanks, bufferOverflow, droppedCount
    );

    // Buffer manager
    modport slave (
        input  isWriting, dataIn, bankReleaseToggle,
        output wrEnable, wrAddr, wrData, bankReadyToggle, readBank,
               occupiedBanks, bufferOverflow, droppedCount
    );
endinterface

// File: rtl/buffer_bank_manager.sv
// N-bank write-side capture buffer manager: fills banks round-robin, announces full banks
// by toggle, frees them on synchronised release toggles and drops samples when all are full.
module buffer_bank_manager #(
    parameter int unsigned DATA_WIDTH    = 10,
    parameter int unsigned BANK_DEPTH    = 8192,
    parameter int unsigned NUM_BANKS     = 4,
    parameter int unsigned OVERFLOW_HOLD = 1000
) (
    input  logic                 writeClock,
    input  logic                 nReset,
    buffer_bank_manager_if.slave bus
);
    localparam int unsigned AW = $clog2(BANK_DEPTH);
    localparam int unsigned IW = $clog2(NUM_BANKS);
    localparam int unsigned OW = IW + 1;
    localparam int unsigned AT = IW + AW;
    localparam int unsigned CW = 16;
    localparam int unsigned HW = (OVERFLOW_HOLD < 1) ? 1 : $clog2(OVERFLOW_HOLD + 1);

    logic [IW-1:0]         write_bank_q, write_bank_d;
    logic [AW-1:0]         word_addr_q, word_addr_d;
    logic [IW-1:0]         read_bank_q, read_bank_d;
    logic [OW-1:0]         occupied_q, occupied_d;
    logic                  wr_enable_q, wr_enable_d;
    logic [AT-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  bank_ready_toggle_q, bank_ready_toggle_d;
    logic                  overflow_q, overflow_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [CW-1:0]         dropped_q, dropped_d;
    logic [2:0]            rel_sync_q, rel_sync_d;

    logic rel_pulse_c;
    logic full_c;
    logic accept_c;
    logic discard_c;
    logic complete_c;
    logic release_c;

    // Qualify the incoming sample and the synchronised release edge
    always_comb begin
        rel_pulse_c = rel_sync_q[1] ^ rel_sync_q[2];
        // All banks can only be occupied at a bank boundary, so a partial bank never stalls
        full_c      = (occupied_q == OW'(NUM_BANKS)) && (word_addr_q == '0);
        accept_c    = bus.isWriting && !full_c;
        discard_c   = bus.isWriting && full_c;
        complete_c  = accept_c && (word_addr_q == AW'(BANK_DEPTH - 1));
        release_c   = rel_pulse_c && (occupied_q != '0);
    end

    // Next-state logic
    always_comb begin
        write_bank_d        = write_bank_q;
        word_addr_d         = word_addr_q;
        read_bank_d         = read_bank_q;
        occupied_d          = occupied_q;
        wr_enable_d         = 1'b0;
        wr_addr_d           = wr_addr_q;
        wr_data_d           = wr_data_q;
        bank_ready_toggle_d = bank_ready_toggle_q;
        overflow_d          = overflow_q;
        hold_d              = hold_q;
        dropped_d           = dropped_q;
        rel_sync_d          = {rel_sync_q[1:0], bus.bankReleaseToggle};

        if (accept_c) begin
            wr_enable_d = 1'b1;
            wr_addr_d   = {write_bank_q, word_addr_q};
            wr_data_d   = bus.dataIn;
            word_addr_d = word_addr_q + AW'(1);
        end

        if (complete_c) begin
            write_bank_d        = write_bank_q + IW'(1);
            bank_ready_toggle_d = ~bank_ready_toggle_q;
        end

        if (release_c) begin
            read_bank_d = read_bank_q + IW'(1);
        end

        // A completion and a release in the same cycle cancel in the occupancy count
        unique case ({complete_c, release_c})
            2'b10:   occupied_d = occupied_q + OW'(1);
            2'b01:   occupied_d = occupied_q - OW'(1);
            default: occupied_d = occupied_q;
        endcase

        if (discard_c) begin
            overflow_d = 1'b1;
            hold_d     = HW'(OVERFLOW_HOLD);
            if (dropped_q != '1) begin
                dropped_d = dropped_q + CW'(1);
            end
        end else if (overflow_q) begin
            if (hold_q == '0) begin
                overflow_d = 1'b0;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end
    end

    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            write_bank_q        <= '0;
            word_addr_q         <= '0;
            read_bank_q         <= '0;
            occupied_q          <= '0;
            wr_enable_q         <= 1'b0;
            wr_addr_q           <= '0;
            wr_data_q           <= '0;
            bank_ready_toggle_q <= 1'b0;
            overflow_q          <= 1'b0;
            hold_q              <= '0;
            dropped_q           <= '0;
            rel_sync_q          <= '0;
        end else begin
            write_bank_q        <= write_bank_d;
            word_addr_q         <= word_addr_d;
            read_bank_q         <= read_bank_d;
            occupied_q          <= occupied_d;
            wr_enable_q         <= wr_enable_d;
            wr_addr_q           <= wr_addr_d;
            wr_data_q           <= wr_data_d;
            bank_ready_toggle_q <= bank_ready_toggle_d;
            overflow_q          <= overflow_d;
            hold_q              <= hold_d;
            dropped_q           <= dropped_d;
            rel_sync_q          <= rel_sync_d;
        end
    end

    assign bus.wrEnable        = wr_enable_q;
    assign bus.wrAddr          = wr_addr_q;
    assign bus.wrData          = wr_data_q;
    assign bus.bankReadyToggle = bank_ready_toggle_q;
    assign bus.readBank        = read_bank_q;
    assign bus.occupiedBanks   = occupied_q;
    assign bus.bufferOverflow  = overflow_q;
    assign bus.droppedCount    = dropped_q;
endmodule

// File: tb/tb_buffer_bank_manager.sv
// Scoreboard bench for buffer_bank_manager: a count-based reference model predicts writes and status,
// a negedge monitor compares them against the DUT.
module tb_buffer_bank_manager;
    localparam int DW = 10;
    localparam int D  = 16;
    localparam int NB = 4;
    localparam int H  = 40;
    localparam int AW = $clog2(D);
    localparam int IW = $clog2(NB);
    localparam int AT = IW + AW;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    buffer_bank_manager_if #(.DATA_WIDTH(DW), .BANK_DEPTH(D), .NUM_BANKS(NB)) bus ();

    buffer_bank_manager #(
        .DATA_WIDTH(DW), .BANK_DEPTH(D), .NUM_BANKS(NB), .OVERFLOW_HOLD(H)
    ) dut (
        .writeClock(clk),
        .nReset    (n_reset),
        .bus       (bus)
    );

    typedef struct packed {
        logic [AT-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;
    int  last_addr = -1;

    // Reference model state: counts of samples written, banks completed/released, drops
    wr_t exp_q[$];
    int  pend[$];
    wr_t wnew, wexp;
    int  m_written = 0, m_completed = 0, m_released = 0, m_dropped = 0, m_occ = 0;
    int  occ_before = 0, last_disc = 0, cyc = 0;
    bit  ever_disc = 1'b0, m_ovf = 1'b0, prev_tog = 1'b0, rel_now = 1'b0, full_now = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        m_written = 0; m_completed = 0; m_released = 0; m_dropped = 0; m_occ = 0;
        ever_disc = 1'b0; m_ovf = 1'b0; prev_tog = 1'b0;
    endtask

    task automatic model_step();
        occ_before = m_completed - m_released;
        rel_now = 1'b0;
        if (pend.size() > 0 && pend[0] == cyc) begin
            rel_now = 1'b1;
            void'(pend.pop_front());
        end
        if (bus.bankReleaseToggle != prev_tog) begin
            pend.push_back(cyc + 2);
            prev_tog = bus.bankReleaseToggle;
        end
        full_now = (occ_before == NB) && (m_written % D == 0);
        if (bus.isWriting) begin
            if (!full_now) begin
                wnew.addr = AT'(((m_written / D) % NB) * D + (m_written % D));
                wnew.data = bus.dataIn;
                exp_q.push_back(wnew);
                m_written++;
                if (m_written % D == 0) m_completed++;
            end else begin
                if (m_dropped < 65535) m_dropped++;
                last_disc = cyc;
                ever_disc = 1'b1;
            end
        end
        if (rel_now && occ_before > 0) m_released++;
        m_occ = m_completed - m_released;
        m_ovf = ever_disc && ((cyc - last_disc) <= H);
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge n_reset);
            if (!n_reset) model_reset();
            else model_step();
        end
    end

    // Monitor: pops the scoreboard on every RAM write and tracks status outputs
    initial begin
        forever begin
            @(negedge clk);
            if (n_reset) begin
                if (bus.wrEnable) begin
                    check("write_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        wexp = exp_q.pop_front();
                        check("wr_addr", int'(bus.wrAddr), int'(wexp.addr));
                        check("wr_data", int'(bus.wrData), int'(wexp.data));
                    end
                    last_addr = int'(bus.wrAddr);
                end
                if (chk_en) begin
                    check("occupied", int'(bus.occupiedBanks), m_occ);
                    check("read_bank", int'(bus.readBank), m_released % NB);
                    check("ready_toggle", int'(bus.bankReadyToggle), m_completed % 2);
                    check("overflow", int'(bus.bufferOverflow), int'(m_ovf));
                    check("dropped", int'(bus.droppedCount), m_dropped);
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input bit w, input int d);
        @(negedge clk);
        bus.isWriting = w;
        bus.dataIn    = DW'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    task automatic flip();
        bus.bankReleaseToggle = ~bus.bankReleaseToggle;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_enable"}, int'(bus.wrEnable), 0);
        check({tag, "_wr_addr"}, int'(bus.wrAddr), 0);
        check({tag, "_wr_data"}, int'(bus.wrData), 0);
        check({tag, "_ready_toggle"}, int'(bus.bankReadyToggle), 0);
        check({tag, "_read_bank"}, int'(bus.readBank), 0);
        check({tag, "_occupied"}, int'(bus.occupiedBanks), 0);
        check({tag, "_overflow"}, int'(bus.bufferOverflow), 0);
        check({tag, "_dropped"}, int'(bus.droppedCount), 0);
    endtask

    int since;
    int rb_saved;
    int guard;

    initial begin
        bus.isWriting = 1'b0;
        bus.dataIn = '0;
        bus.bankReleaseToggle = 1'b0;
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_reset = 1'b1;
        chk_en = 1'b1;

        // Fill one bank with 0..15
        for (int i = 0; i < D; i++) step(1'b1, i);
        idle(2);
        check("fill_toggle", int'(bus.bankReadyToggle), 1);
        check("fill_occupied", int'(bus.occupiedBanks), 1);
        check("fill_last_addr", last_addr, 15);

        // 70 samples from empty: 64 writes and 6 discards
        for (int i = D; i < 70; i++) step(1'b1, int'($urandom));
        idle(2);
        check("full_occupied", int'(bus.occupiedBanks), 4);
        check("full_dropped", int'(bus.droppedCount), 6);
        check("full_overflow", int'(bus.bufferOverflow), 1);
        idle(H - 2);
        check("overflow_held", int'(bus.bufferOverflow), 1);
        idle(3);
        check("overflow_cleared", int'(bus.bufferOverflow), 0);

        // Single release: three-cycle latency
        step(1'b0, 0);
        flip();
        idle(2);
        check("release_latency_occ", int'(bus.occupiedBanks), 4);
        idle(1);
        check("release_occ", int'(bus.occupiedBanks), 3);
        check("release_read_bank", int'(bus.readBank), 1);
        step(1'b1, int'($urandom));
        idle(2);
        check("after_release_addr", last_addr, 0);

        // Release pulse aligned with the last word of bank 0
        for (int k = 1; k < D; k++) begin
            step(1'b1, int'($urandom));
            if (k == D - 3) flip();
        end
        idle(2);
        check("simul_occ", int'(bus.occupiedBanks), 3);
        check("simul_read_bank", int'(bus.readBank), 2);
        step(1'b1, int'($urandom));
        idle(2);
        check("simul_write_bank", last_addr, D);

        // Random traffic and releases
        since = 0;
        repeat (2000) begin
            step(($urandom % 4) != 0, int'($urandom));
            since++;
            if (since >= 4 && ($urandom % 5) == 0) begin
                flip();
                since = 0;
            end
        end
        idle(4);

        // Drain every bank, then a spurious release
        guard = 0;
        while (m_occ > 0 && guard < 20) begin
            step(1'b0, 0);
            flip();
            idle(4);
            guard++;
        end
        check("drained_occ", int'(bus.occupiedBanks), 0);
        rb_saved = m_released % NB;
        step(1'b0, 0);
        flip();
        idle(4);
        check("spurious_occ", int'(bus.occupiedBanks), 0);
        check("spurious_read_bank", int'(bus.readBank), rb_saved);

        // Saturate the drop counter
        guard = 0;
        while (!(m_occ == NB && (m_written % D) == 0) && guard < 200) begin
            step(1'b1, int'($urandom));
            guard++;
        end
        check("sat_reached_full", int'(guard < 200), 1);
        chk_en = 1'b0;
        repeat (70000) step(1'b1, int'($urandom));
        idle(2);
        check("sat_dropped", int'(bus.droppedCount), 65535);
        check("sat_overflow", int'(bus.bufferOverflow), 1);
        chk_en = 1'b1;

        // Reset partway through a bank
        step(1'b0, 0);
        flip();
        idle(4);
        for (int i = 0; i < 7; i++) step(1'b1, int'($urandom));
        idle(2);
        n_reset = 1'b0;
        last_addr = -1;
        @(negedge clk);
        check_reset_outputs("midreset");
        n_reset = 1'b1;
        step(1'b1, int'($urandom));
        idle(2);
        check("post_reset_addr", last_addr, 0);
        check("post_reset_occ", int'(bus.occupiedBanks), 0);

        idle(4);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
